// File: rtl/prio_encoder_serial.sv
// Serial priority encoder: latches an N-bit request vector and emits the index
// of every set bit, one beat per handshake, in priority order with a last flag.
module prio_encoder_serial #(
    parameter int unsigned N         = 4,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         err_empty
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic         err_empty_q, err_empty_d;
    logic [N-1:0] sel;
    logic         single;

    // Highest-priority pending bit; the last match in loop order wins.
    always_comb begin
        out_idx = '0;
        if (LSB_FIRST) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending_q[i]) out_idx = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) out_idx = W'(i);
            end
        end
    end

    always_comb begin
        sel          = '0;
        sel[out_idx] = 1'b1;
    end

    assign single    = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
    assign out_valid = (state_q == StBusy);
    assign out_last  = out_valid && single;
    assign in_ready  = (state_q == StIdle) || (out_valid && out_ready && out_last);
    assign err_empty = err_empty_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        err_empty_d = 1'b0;
        if (out_valid && out_ready) begin
            pending_d = pending_q & ~sel;
            if (out_last) state_d = StIdle;
        end
        // A load on the final beat overrides the drain-complete return to idle.
        if (in_valid && in_ready) begin
            if (in_vec != '0) begin
                pending_d = in_vec;
                state_d   = StBusy;
            end else begin
                err_empty_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            err_empty_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            err_empty_q <= err_empty_d;
        end
    end

endmodule
